// File: rtl/jt12_opacc_pkg.sv
// Shared definitions for the operator-output accumulator: slot groups,
// key slot indices and the algorithm carrier table.
package jt12_opacc_defs;

  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_t;

  localparam logic [4:0] LAST_SLOT = 5'd23;
  localparam logic [4:0] MIX_START = 5'd18;

  function automatic grp_t slot_grp(input logic [4:0] slot);
    grp_t g;
    if (slot < 5'd6)       g = GRP_S1;
    else if (slot < 5'd12) g = GRP_S3;
    else if (slot < 5'd18) g = GRP_S2;
    else                   g = GRP_S4;
    return g;
  endfunction

  function automatic logic is_carrier(input grp_t grp, input logic [2:0] alg);
    logic c;
    case (grp)
      GRP_S4:  c = 1'b1;
      GRP_S2:  c = (alg >= 3'd4);
      GRP_S3:  c = (alg >= 3'd5);
      default: c = (alg == 3'd7);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/jt12_opacc_mix.sv
// Stereo mixer: accumulates the six per-channel carrier totals of the S4
// group into left/right sums and registers one stereo sample per cycle.
module jt12_opacc_mix #(
  parameter int out_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             valid,
  input  logic [4:0]       slot,
  input  logic [10:0]      total,
  input  logic [1:0]       rl,
  output logic [out_w-1:0] snd_left,
  output logic [out_w-1:0] snd_right,
  output logic             sample
);
  import jt12_opacc_defs::*;

  logic signed [13:0]      acc_l, acc_r;
  logic signed [13:0]      gate_l, gate_r;
  logic signed [13:0]      fin_l, fin_r;
  logic signed [out_w-1:0] ext_l, ext_r;

  always_comb begin
    gate_l = rl[1] ? 14'($signed(total)) : '0;
    gate_r = rl[0] ? 14'($signed(total)) : '0;
    fin_l  = acc_l + gate_l;
    fin_r  = acc_r + gate_r;
    ext_l  = out_w'(fin_l);
    ext_r  = out_w'(fin_r);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_l     <= '0;
      acc_r     <= '0;
      snd_left  <= '0;
      snd_right <= '0;
      sample    <= 1'b0;
    end else if (clk_en) begin
      sample <= valid && (slot == LAST_SLOT);
      if (valid) begin
        if (slot == MIX_START) begin
          acc_l <= gate_l;
          acc_r <= gate_r;
        end else if (slot == LAST_SLOT) begin
          snd_left  <= ext_l <<< 2;
          snd_right <= ext_r <<< 2;
        end else begin
          acc_l <= fin_l;
          acc_r <= fin_r;
        end
      end
    end
  end

endmodule

// File: rtl/jt12_sh.sv
// Generic multi-bit shift register advancing on clk_en.
module jt12_sh #(
  parameter int width  = 5,
  parameter int stages = 24
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic             rst,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  logic [width-1:0] bits [stages];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < stages; i++) bits[i] <= '0;
    end else if (clk_en) begin
      bits[0] <= din;
      for (int unsigned i = 1; i < stages; i++) bits[i] <= bits[i-1];
    end
  end

  assign drop = bits[stages-1];

endmodule

// File: rtl/jt12_opacc.sv
// Channel accumulator: sums carrier operators per channel over the
// S1/S3/S2/S4 slot groups and feeds per-channel totals to the stereo mixer.
module jt12_opacc #(
  parameter int num_ch = 6,
  parameter int out_w  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  input  logic [8:0]       op_result,
  input  logic [2:0]       alg,
  input  logic [1:0]       rl,
  output logic [10:0]      ch_sum,
  output logic             ch_valid,
  output logic [out_w-1:0] snd_left,
  output logic [out_w-1:0] snd_right,
  output logic             sample
);
  import jt12_opacc_defs::*;

  logic [4:0]         cnt, slot;
  grp_t               grp;
  logic               s4;
  logic signed [10:0] contrib, stage, total, din;
  logic [10:0]        stage_raw;

  // zero forces the current input to be treated as slot 0, so a resync
  // re-enters the S1 load and discards any partial channel sums.
  always_comb begin
    slot    = zero ? '0 : cnt;
    grp     = slot_grp(slot);
    s4      = (grp == GRP_S4);
    contrib = is_carrier(grp, alg) ? 11'($signed(op_result)) : '0;
    stage   = $signed(stage_raw);
    total   = stage + contrib;
    din     = (grp == GRP_S1) ? contrib : total;
  end

  jt12_sh #(
    .width (11),
    .stages(num_ch)
  ) u_sh (
    .clk   (clk),
    .clk_en(clk_en),
    .rst   (rst),
    .din   (din),
    .drop  (stage_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      ch_sum   <= '0;
      ch_valid <= 1'b0;
    end else if (clk_en) begin
      cnt      <= (slot == LAST_SLOT) ? '0 : slot + 5'd1;
      ch_valid <= s4;
      if (s4) ch_sum <= total;
    end
  end

  jt12_opacc_mix #(
    .out_w(out_w)
  ) u_mix (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .valid    (s4),
    .slot     (slot),
    .total    (total),
    .rl       (rl),
    .snd_left (snd_left),
    .snd_right(snd_right),
    .sample   (sample)
  );

endmodule

// File: tb/tb_jt12_opacc.sv
// Scoreboard bench for jt12_opacc: directed per-cycle operator patterns with
// hand-computed channel sums and stereo samples.
module tb_jt12_opacc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        zero = 1'b0;
  logic [8:0]  op_result = '0;
  logic [2:0]  alg = '0;
  logic [1:0]  rl = '0;
  logic [10:0] ch_sum;
  logic        ch_valid;
  logic [15:0] snd_left, snd_right;
  logic        sample;

  jt12_opacc #(
    .num_ch(6),
    .out_w (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .zero     (zero),
    .op_result(op_result),
    .alg      (alg),
    .rl       (rl),
    .ch_sum   (ch_sum),
    .ch_valid (ch_valid),
    .snd_left (snd_left),
    .snd_right(snd_right),
    .sample   (sample)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] sum;
    int          cyc;
  } ch_exp_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } smp_exp_t;

  ch_exp_t  ch_q[$];
  smp_exp_t smp_q[$];
  ch_exp_t  ce;
  smp_exp_t se;

  int   checks = 0;
  int   errors = 0;
  int   n_issue = 0;
  int   en_cyc = 0;
  logic mon_en;

  // Monitor: every enabled edge outside reset is numbered; strobes pop the
  // scoreboard and must match both value and the cycle it was expected on.
  always @(posedge clk) begin
    mon_en = clk_en && rst;
    #1;
    if (mon_en) begin
      en_cyc++;
      if (ch_valid) begin
        checks++;
        if (ch_q.size() == 0) begin
          errors++;
          $display("FAIL ch_sum_unexpected: got %0d at cycle %0d, expected no strobe",
                   $signed(ch_sum), en_cyc);
        end else begin
          ce = ch_q.pop_front();
          if (ch_sum !== ce.sum || en_cyc != ce.cyc) begin
            errors++;
            $display("FAIL ch_sum: got %0d at cycle %0d, expected %0d at cycle %0d",
                     $signed(ch_sum), en_cyc, $signed(ce.sum), ce.cyc);
          end
        end
      end
      if (sample) begin
        checks++;
        if (smp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got L=%0d R=%0d at cycle %0d, expected no sample",
                   $signed(snd_left), $signed(snd_right), en_cyc);
        end else begin
          se = smp_q.pop_front();
          if (snd_left !== se.l || snd_right !== se.r || en_cyc != se.cyc) begin
            errors++;
            $display("FAIL sample: got L=%0d R=%0d at cycle %0d, expected L=%0d R=%0d at cycle %0d",
                     $signed(snd_left), $signed(snd_right), en_cyc,
                     $signed(se.l), $signed(se.r), se.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic z, input logic [8:0] op, input logic [2:0] a,
                       input logic [1:0] r, input logic gap);
    if (gap) begin
      @(negedge clk);
      clk_en    = 1'b0;
      zero      = 1'b0;
      op_result = 9'($urandom);
    end
    @(negedge clk);
    clk_en    = 1'b1;
    zero      = z;
    op_result = op;
    alg       = a;
    rl        = r;
    n_issue++;
  endtask

  // ops given in slot order S1,S3,S2,S4; rlv holds ch0 in bits [1:0].
  task automatic run_pattern(input logic [2:0] a, input logic [8:0] o1, input logic [8:0] o3,
                             input logic [8:0] o2, input logic [8:0] o4, input logic [11:0] rlv,
                             input logic zero_first, input int n, input logic gaps,
                             input logic [10:0] exp_sum, input logic [15:0] exp_l,
                             input logic [15:0] exp_r);
    int         grp, ch;
    logic [8:0] op;
    logic [1:0] r;
    for (int s = 0; s < n; s++) begin
      grp = s / 6;
      ch  = s % 6;
      case (grp)
        0:       op = o1;
        1:       op = o3;
        2:       op = o2;
        default: op = o4;
      endcase
      r = (grp == 3) ? rlv[ch*2 +: 2] : ~rlv[ch*2 +: 2];
      issue(zero_first && s == 0, op, a, r, gaps && (s % 5 == 3));
      if (grp == 3) ch_q.push_back('{sum: exp_sum, cyc: n_issue});
      if (s == 23) smp_q.push_back('{l: exp_l, r: exp_r, cyc: n_issue});
    end
  endtask

  initial begin
    // Reset with zero and clk_en active: reset must win.
    rst = 1'b0; clk_en = 1'b1; zero = 1'b1; op_result = 9'h155; alg = 3'd7; rl = 2'b11;
    repeat (4) @(negedge clk);
    check("reset_ch_sum", {5'b0, ch_sum}, 16'h0000);
    check("reset_ch_valid", {15'b0, ch_valid}, 16'h0000);
    check("reset_snd_left", snd_left, 16'h0000);
    check("reset_snd_right", snd_right, 16'h0000);
    check("reset_sample", {15'b0, sample}, 16'h0000);
    rst = 1'b1; clk_en = 1'b0; zero = 1'b0;

    run_pattern(3'd7, 9'd100, 9'd100, 9'd100, 9'd100, 12'hFFF, 1'b1, 24, 1'b0,
                11'd400, 16'd9600, 16'd9600);
    run_pattern(3'd7, 9'd100, 9'd100, 9'd100, 9'd100, 12'hFFF, 1'b0, 24, 1'b1,
                11'd400, 16'd9600, 16'd9600);
    run_pattern(3'd0, 9'd255, 9'd255, 9'd255, 9'h1CE, 12'hFFF, 1'b1, 24, 1'b0,
                11'h7CE, 16'hFB50, 16'hFB50);
    run_pattern(3'd4, 9'd77, 9'h1DF, 9'h100, 9'h100, 12'h002, 1'b1, 24, 1'b0,
                11'h600, 16'hF800, 16'h0000);
    run_pattern(3'd3, 9'd255, 9'd255, 9'd255, 9'd7, 12'hFFF, 1'b0, 24, 1'b0,
                11'd7, 16'd168, 16'd168);
    run_pattern(3'd5, 9'd10, 9'd20, 9'd30, 9'd40, 12'h8DA, 1'b1, 24, 1'b1,
                11'd90, 16'd1440, 16'd720);
    run_pattern(3'd7, 9'h100, 9'h100, 9'h100, 9'h100, 12'hFFF, 1'b1, 24, 1'b0,
                11'h400, 16'hA000, 16'hA000);

    // Truncated before any S4 slot, then resync at slot 10.
    run_pattern(3'd7, 9'h100, 9'h100, 9'h100, 9'h100, 12'hFFF, 1'b1, 10, 1'b0,
                11'h400, 16'hA000, 16'hA000);
    run_pattern(3'd7, 9'd100, 9'd100, 9'd100, 9'd100, 12'hFFF, 1'b1, 24, 1'b0,
                11'd400, 16'd9600, 16'd9600);
    // Truncated after the mix has started: no sample, partial mix discarded.
    run_pattern(3'd7, 9'h100, 9'h100, 9'h100, 9'h100, 12'hFFF, 1'b0, 21, 1'b0,
                11'h400, 16'hA000, 16'hA000);
    run_pattern(3'd7, 9'd100, 9'd100, 9'd100, 9'd100, 12'hFFF, 1'b1, 24, 1'b0,
                11'd400, 16'd9600, 16'd9600);

    // Reset at slot 20 with clk_en low.
    run_pattern(3'd4, 9'd77, 9'h1DF, 9'h100, 9'h100, 12'h002, 1'b0, 20, 1'b0,
                11'h600, 16'hF800, 16'h0000);
    @(negedge clk);
    clk_en = 1'b0; rst = 1'b0;
    @(posedge clk);
    #2;
    check("midreset_ch_sum", {5'b0, ch_sum}, 16'h0000);
    check("midreset_ch_valid", {15'b0, ch_valid}, 16'h0000);
    check("midreset_snd_left", snd_left, 16'h0000);
    check("midreset_snd_right", snd_right, 16'h0000);
    check("midreset_sample", {15'b0, sample}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    run_pattern(3'd7, 9'd100, 9'd100, 9'd100, 9'd100, 12'hFFF, 1'b0, 24, 1'b0,
                11'd400, 16'd9600, 16'd9600);

    @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    check("pending_ch_sum", 16'(ch_q.size()), 16'h0000);
    check("pending_sample", 16'(smp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1);
  end

endmodule
